// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single 256-bit dmem port between requester 0 (SIMD load/store unit)
// and requester 1 (DMA/debug scanner).
// - IDLE arbitration is round-robin; a granted transaction with lock=1 keeps ownership so the
//   owner can run back-to-back sequences such as read-modify-write.
// - The RAM side is registered: a transaction granted in cycle T appears on ram_* in T+1.
// - A READ_LATENCY-deep {valid, id} tracker steers ram_rdata back to the requester that issued
//   the read. rvalid pulses in T+1+READ_LATENCY.
// Build option: define DMEM_ARB_FIXED_PRIO_EN to make IDLE arbitration fixed priority, with r0
// always winning. The round-robin pointer is then not built.
module dmem_arbiter #(
    parameter int unsigned ADDR_W       = 14,
    parameter int unsigned DATA_W       = 256,
    parameter int unsigned BE_W         = 32,
    parameter int unsigned READ_LATENCY = 2
) (
    input  logic              clk,
    input  logic              reset,
    // requester 0
    input  logic              r0_req,
    input  logic              r0_we,
    input  logic              r0_lock,
    input  logic [ADDR_W-1:0] r0_addr,
    input  logic [BE_W-1:0]   r0_be,
    input  logic [DATA_W-1:0] r0_wdata,
    output logic              r0_gnt,
    output logic              r0_rvalid,
    output logic [DATA_W-1:0] r0_rdata,
    // requester 1
    input  logic              r1_req,
    input  logic              r1_we,
    input  logic              r1_lock,
    input  logic [ADDR_W-1:0] r1_addr,
    input  logic [BE_W-1:0]   r1_be,
    input  logic [DATA_W-1:0] r1_wdata,
    output logic              r1_gnt,
    output logic              r1_rvalid,
    output logic [DATA_W-1:0] r1_rdata,
    // dmem side
    output logic [ADDR_W-1:0] ram_address,
    output logic [BE_W-1:0]   ram_byteena,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_rden,
    output logic              ram_wren,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              busy
);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StOwn0 = 2'd1,
        StOwn1 = 2'd2
    } state_e;

    state_e              r_state;
    state_e              w_state_next;

    logic                w_gnt0;
    logic                w_gnt1;
    logic                w_gnt_any;
    logic                w_sel_we;
    logic [ADDR_W-1:0]   w_sel_addr;
    logic [BE_W-1:0]     w_sel_be;
    logic [DATA_W-1:0]   w_sel_wdata;

    logic [ADDR_W-1:0]   r_ram_address;
    logic [BE_W-1:0]     r_ram_byteena;
    logic [DATA_W-1:0]   r_ram_wdata;
    logic                r_ram_rden;
    logic                r_ram_wren;

    // r_issue_id is the requester id paired with r_ram_rden (the read currently on the RAM port)
    logic                    r_issue_id;
    logic [READ_LATENCY-1:0] r_trk_vld;
    logic [READ_LATENCY-1:0] r_trk_id;

    logic                w_rv0;
    logic                w_rv1;
    logic [DATA_W-1:0]   r_rdata0;
    logic [DATA_W-1:0]   r_rdata1;

`ifndef DMEM_ARB_FIXED_PRIO_EN
    // r_rr = 1 means r1 wins the next IDLE contention
    logic                r_rr;
    logic                w_contend;

    assign w_contend = (r_state == StIdle) & r0_req & r1_req;

    // Round-robin pointer: flips each time an IDLE contention is resolved
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rr <= 1'b0;
        end else if (w_contend) begin
            r_rr <= ~r_rr;
        end
    end
`endif

    // FSM state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next state: a grant decides ownership from its lock bit; an owner that stops
    // requesting hands back to IDLE without a grant that cycle
    always_comb begin
        w_state_next = r_state;
        if (w_gnt0) begin
            w_state_next = r0_lock ? StOwn0 : StIdle;
        end else if (w_gnt1) begin
            w_state_next = r1_lock ? StOwn1 : StIdle;
        end else begin
            w_state_next = StIdle;
        end
    end

    // FSM outputs: combinational grants, at most one per cycle
    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        case (r_state)
            StIdle: begin
                if (r0_req && r1_req) begin
`ifdef DMEM_ARB_FIXED_PRIO_EN
                    w_gnt0 = 1'b1;
`else
                    w_gnt0 = ~r_rr;
                    w_gnt1 = r_rr;
`endif
                end else begin
                    w_gnt0 = r0_req;
                    w_gnt1 = r1_req;
                end
            end
            StOwn0:  w_gnt0 = r0_req;
            StOwn1:  w_gnt1 = r1_req;
            default: begin
                w_gnt0 = 1'b0;
                w_gnt1 = 1'b0;
            end
        endcase
    end

    assign r0_gnt    = w_gnt0;
    assign r1_gnt    = w_gnt1;
    assign w_gnt_any = w_gnt0 | w_gnt1;

    // Steer the granted requester's transaction towards the RAM registers
    always_comb begin
        if (w_gnt1) begin
            w_sel_we    = r1_we;
            w_sel_addr  = r1_addr;
            w_sel_be    = r1_be;
            w_sel_wdata = r1_wdata;
        end else begin
            w_sel_we    = r0_we;
            w_sel_addr  = r0_addr;
            w_sel_be    = r0_be;
            w_sel_wdata = r0_wdata;
        end
    end

    // RAM-side register: strobes every cycle, address/data only on a grant so they hold when idle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ram_address <= '0;
            r_ram_byteena <= '0;
            r_ram_wdata   <= '0;
            r_ram_rden    <= 1'b0;
            r_ram_wren    <= 1'b0;
        end else begin
            r_ram_rden <= w_gnt_any & ~w_sel_we;
            r_ram_wren <= w_gnt_any & w_sel_we;
            if (w_gnt_any) begin
                r_ram_address <= w_sel_addr;
                r_ram_byteena <= w_sel_we ? w_sel_be : {BE_W{1'b1}};
                r_ram_wdata   <= w_sel_wdata;
            end
        end
    end

    assign ram_address = r_ram_address;
    assign ram_byteena = r_ram_byteena;
    assign ram_wdata   = r_ram_wdata;
    assign ram_rden    = r_ram_rden;
    assign ram_wren    = r_ram_wren;

    // Read tracker: the oldest stage lines up with ram_rdata being valid
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_issue_id <= 1'b0;
            r_trk_vld  <= '0;
            r_trk_id   <= '0;
        end else begin
            r_issue_id   <= w_gnt1;
            r_trk_vld[0] <= r_ram_rden;
            r_trk_id[0]  <= r_issue_id;
            for (int unsigned i = 1; i < READ_LATENCY; i++) begin
                r_trk_vld[i] <= r_trk_vld[i-1];
                r_trk_id[i]  <= r_trk_id[i-1];
            end
        end
    end

    assign w_rv0 = r_trk_vld[READ_LATENCY-1] & ~r_trk_id[READ_LATENCY-1];
    assign w_rv1 = r_trk_vld[READ_LATENCY-1] & r_trk_id[READ_LATENCY-1];

    // Per-requester read data hold: keeps the last returned word until the next rvalid
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rdata0 <= '0;
            r_rdata1 <= '0;
        end else begin
            if (w_rv0) begin
                r_rdata0 <= ram_rdata;
            end
            if (w_rv1) begin
                r_rdata1 <= ram_rdata;
            end
        end
    end

    assign r0_rvalid = w_rv0;
    assign r1_rvalid = w_rv1;
    assign r0_rdata  = w_rv0 ? ram_rdata : r_rdata0;
    assign r1_rdata  = w_rv1 ? ram_rdata : r_rdata1;

    assign busy = (r_state != StIdle) | r_ram_rden | (|r_trk_vld);

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed bench for dmem_arbiter with a behavioural dmem.
// The bench RAM samples address on the clock edge after ram_rden and presents data two cycles
// after the rden cycle. Unwritten words read as {8{32'hC0DE_0000 | addr}}.
module tb_dmem_arbiter;

    localparam int unsigned ADDR_W       = 14;
    localparam int unsigned DATA_W       = 256;
    localparam int unsigned BE_W         = 32;
    localparam int unsigned READ_LATENCY = 2;
    localparam int unsigned DEPTH        = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              reset;
    logic              r0_req, r0_we, r0_lock, r0_gnt, r0_rvalid;
    logic [ADDR_W-1:0] r0_addr;
    logic [BE_W-1:0]   r0_be;
    logic [DATA_W-1:0] r0_wdata, r0_rdata;
    logic              r1_req, r1_we, r1_lock, r1_gnt, r1_rvalid;
    logic [ADDR_W-1:0] r1_addr;
    logic [BE_W-1:0]   r1_be;
    logic [DATA_W-1:0] r1_wdata, r1_rdata;
    logic [ADDR_W-1:0] ram_address;
    logic [BE_W-1:0]   ram_byteena;
    logic [DATA_W-1:0] ram_wdata, ram_rdata;
    logic              ram_rden, ram_wren, busy;

    int errors = 0;
    int checks = 0;

    dmem_arbiter #(
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W),
        .BE_W        (BE_W),
        .READ_LATENCY(READ_LATENCY)
    ) u_dut (
        .clk        (clk),
        .reset      (reset),
        .r0_req     (r0_req),
        .r0_we      (r0_we),
        .r0_lock    (r0_lock),
        .r0_addr    (r0_addr),
        .r0_be      (r0_be),
        .r0_wdata   (r0_wdata),
        .r0_gnt     (r0_gnt),
        .r0_rvalid  (r0_rvalid),
        .r0_rdata   (r0_rdata),
        .r1_req     (r1_req),
        .r1_we      (r1_we),
        .r1_lock    (r1_lock),
        .r1_addr    (r1_addr),
        .r1_be      (r1_be),
        .r1_wdata   (r1_wdata),
        .r1_gnt     (r1_gnt),
        .r1_rvalid  (r1_rvalid),
        .r1_rdata   (r1_rdata),
        .ram_address(ram_address),
        .ram_byteena(ram_byteena),
        .ram_wdata  (ram_wdata),
        .ram_rden   (ram_rden),
        .ram_wren   (ram_wren),
        .ram_rdata  (ram_rdata),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural dmem ----------------
    bit   [DATA_W-1:0] mem_data [DEPTH];
    bit   [DEPTH-1:0]  mem_wr;
    logic [DATA_W-1:0] rd_pipe0, rd_pipe1;

    function automatic logic [DATA_W-1:0] dflt(input logic [ADDR_W-1:0] a);
        logic [31:0] w;
        w = 32'hC0DE_0000 | {18'd0, a};
        return {8{w}};
    endfunction

    function automatic logic [DATA_W-1:0] mem_rd(input logic [ADDR_W-1:0] a);
        return mem_wr[a] ? mem_data[a] : dflt(a);
    endfunction

    function automatic logic [DATA_W-1:0] merge(input logic [DATA_W-1:0] old_w,
                                                input logic [DATA_W-1:0] new_w,
                                                input logic [BE_W-1:0]   be);
        logic [DATA_W-1:0] r;
        r = old_w;
        for (int i = 0; i < BE_W; i++) begin
            if (be[i]) r[8*i +: 8] = new_w[8*i +: 8];
        end
        return r;
    endfunction

    always @(posedge clk) begin
        rd_pipe0 <= mem_rd(ram_address);
        rd_pipe1 <= rd_pipe0;
        if (ram_wren) begin
            mem_data[ram_address] <= merge(mem_rd(ram_address), ram_wdata, ram_byteena);
            mem_wr[ram_address]   <= 1'b1;
        end
    end
    assign ram_rdata = rd_pipe1;

    // ---------------- stimulus helpers ----------------
    task automatic clear_inputs();
        r0_req = 1'b0; r0_we = 1'b0; r0_lock = 1'b0; r0_addr = '0; r0_be = '0; r0_wdata = '0;
        r1_req = 1'b0; r1_we = 1'b0; r1_lock = 1'b0; r1_addr = '0; r1_be = '0; r1_wdata = '0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        clear_inputs();
        reset = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++;
            $display("FAIL rst_busy: got %b want 0", busy); end
        checks++; if (ram_rden !== 1'b0 || ram_wren !== 1'b0) begin errors++;
            $display("FAIL rst_strobes: got rden=%b wren=%b want 0/0", ram_rden, ram_wren); end
        checks++; if (ram_address !== '0) begin errors++;
            $display("FAIL rst_addr: got %h want 0", ram_address); end
        checks++; if (ram_byteena !== '0) begin errors++;
            $display("FAIL rst_be: got %h want 0", ram_byteena); end
        checks++; if (r0_rvalid !== 1'b0 || r1_rvalid !== 1'b0) begin errors++;
            $display("FAIL rst_rvalid: got %b/%b want 0/0", r0_rvalid, r1_rvalid); end
        checks++; if (r0_rdata !== '0 || r1_rdata !== '0) begin errors++;
            $display("FAIL rst_rdata: got %h / %h want 0", r0_rdata, r1_rdata); end
        next_cycle();
    endtask

    task automatic test_reset_mid_read();
        reset = 1'b1;
        r0_req = 1'b1; r0_addr = 14'h0010;
        @(negedge clk);
        checks++; if (r0_gnt !== 1'b1 || r1_gnt !== 1'b0) begin errors++;
            $display("FAIL mr_gnt: got %b/%b want 1/0", r0_gnt, r1_gnt); end
        next_cycle();
        r0_req = 1'b0;
        @(negedge clk);
        checks++; if (ram_rden !== 1'b1 || ram_wren !== 1'b0) begin errors++;
            $display("FAIL mr_rden: got rden=%b wren=%b want 1/0", ram_rden, ram_wren); end
        checks++; if (ram_address !== 14'h0010) begin errors++;
            $display("FAIL mr_addr: got %h want 0010", ram_address); end
        checks++; if (ram_byteena !== 32'hFFFF_FFFF) begin errors++;
            $display("FAIL mr_rd_be: got %h want ffffffff", ram_byteena); end
        checks++; if (busy !== 1'b1) begin errors++;
            $display("FAIL mr_busy: got %b want 1", busy); end
        next_cycle();
        @(negedge clk);
        checks++; if (r0_rvalid !== 1'b0) begin errors++;
            $display("FAIL mr_early_rvalid: got %b want 0", r0_rvalid); end
        next_cycle();
        @(negedge clk);
        checks++; if (r0_rvalid !== 1'b1 || r1_rvalid !== 1'b0) begin errors++;
            $display("FAIL mr_rvalid: got %b/%b want 1/0", r0_rvalid, r1_rvalid); end
        checks++; if (r0_rdata !== dflt(14'h0010)) begin errors++;
            $display("FAIL mr_rdata: got %h want %h", r0_rdata, dflt(14'h0010)); end
        next_cycle();
        @(negedge clk);
        checks++; if (r0_rvalid !== 1'b0 || r0_rdata !== dflt(14'h0010)) begin errors++;
            $display("FAIL mr_hold: got v=%b %h want 0 %h", r0_rvalid, r0_rdata,
                     dflt(14'h0010)); end
        checks++; if (busy !== 1'b0) begin errors++;
            $display("FAIL mr_busy_drain: got %b want 0", busy); end
        next_cycle();
        // second read, killed by reset one cycle after its grant
        r0_req = 1'b1; r0_addr = 14'h0011;
        @(negedge clk);
        checks++; if (r0_gnt !== 1'b1) begin errors++;
            $display("FAIL mr2_gnt: got %b want 1", r0_gnt); end
        next_cycle();
        r0_req = 1'b0;
        reset  = 1'b0;
        @(negedge clk);
        checks++; if (busy !== 1'b0 || ram_rden !== 1'b0) begin errors++;
            $display("FAIL mr2_reset: got busy=%b rden=%b want 0/0", busy, ram_rden); end
        next_cycle();
        next_cycle();
        reset = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++; if (r0_rvalid !== 1'b0 || r1_rvalid !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL mr2_discard[%0d]: got rv=%b/%b busy=%b want 0/0/0", k,
                         r0_rvalid, r1_rvalid, busy);
            end
            next_cycle();
        end
    endtask

    task automatic test_contention();
        bit                e0 [16];
        bit                e1 [16];
        logic [ADDR_W-1:0] a0 [16];
        logic [ADDR_W-1:0] a1 [16];
        int                n0 = 0;
        int                n1 = 0;
        bit                g0, g1;
        for (int i = 0; i < 16; i++) begin
            e0[i] = 1'b0; e1[i] = 1'b0; a0[i] = '0; a1[i] = '0;
        end
        for (int k = 0; k < 10; k++) begin
            r0_req  = (k < 6); r0_addr = 14'h0100 + 14'(n0);
            r1_req  = (k < 6); r1_addr = 14'h0200 + 14'(n1);
`ifdef DMEM_ARB_FIXED_PRIO_EN
            g0 = (k < 6);
            g1 = 1'b0;
`else
            g0 = (k < 6) && (k % 2 == 0);
            g1 = (k < 6) && (k % 2 == 1);
`endif
            @(negedge clk);
            checks++; if (r0_gnt !== g0 || r1_gnt !== g1) begin errors++;
                $display("FAIL rr_gnt[%0d]: got %b/%b want %b/%b", k, r0_gnt, r1_gnt, g0, g1); end
            checks++; if (r0_rvalid !== e0[k] || r1_rvalid !== e1[k]) begin errors++;
                $display("FAIL rr_rvalid[%0d]: got %b/%b want %b/%b", k, r0_rvalid, r1_rvalid,
                         e0[k], e1[k]); end
            if (e0[k]) begin
                checks++; if (r0_rdata !== dflt(a0[k])) begin errors++;
                    $display("FAIL rr_rdata0[%0d]: got %h want %h", k, r0_rdata, dflt(a0[k])); end
            end
            if (e1[k]) begin
                checks++; if (r1_rdata !== dflt(a1[k])) begin errors++;
                    $display("FAIL rr_rdata1[%0d]: got %h want %h", k, r1_rdata, dflt(a1[k])); end
            end
            if (g0) begin e0[k+3] = 1'b1; a0[k+3] = r0_addr; n0++; end
            if (g1) begin e1[k+3] = 1'b1; a1[k+3] = r1_addr; n1++; end
            next_cycle();
        end
        clear_inputs();
    endtask

    task automatic test_lock();
        logic [DATA_W-1:0] wd;
        logic [DATA_W-1:0] exp_rd;
        wd     = {8{32'h1122_3344}};
        exp_rd = {{7{32'hC0DE_0040}}, 32'h1122_3344};
        // A: r1 locked write
        r1_req = 1'b1; r1_we = 1'b1; r1_lock = 1'b1; r1_addr = 14'h0040;
        r1_be = 32'h0000_000F; r1_wdata = wd;
        @(negedge clk);
        checks++; if (r1_gnt !== 1'b1 || r0_gnt !== 1'b0) begin errors++;
            $display("FAIL lk_a_gnt: got %b/%b want 0/1", r0_gnt, r1_gnt); end
        next_cycle();
        // B: r0 starts requesting, r1 read with lock released
        r0_req = 1'b1; r0_we = 1'b0; r0_addr = 14'h0020;
        r1_we = 1'b0; r1_lock = 1'b0;
        @(negedge clk);
        checks++; if (r0_gnt !== 1'b0 || r1_gnt !== 1'b1) begin errors++;
            $display("FAIL lk_b_gnt: got %b/%b want 0/1", r0_gnt, r1_gnt); end
        checks++; if (ram_wren !== 1'b1 || ram_address !== 14'h0040
                      || ram_byteena !== 32'h0000_000F || ram_wdata !== wd) begin errors++;
            $display("FAIL lk_b_wr: got wren=%b addr=%h be=%h want 1 0040 0000000f",
                     ram_wren, ram_address, ram_byteena); end
        checks++; if (busy !== 1'b1) begin errors++;
            $display("FAIL lk_b_busy: got %b want 1", busy); end
        next_cycle();
        // C: r1 done, r0 finally granted
        r1_req = 1'b0;
        @(negedge clk);
        checks++; if (r0_gnt !== 1'b1 || r1_gnt !== 1'b0) begin errors++;
            $display("FAIL lk_c_gnt: got %b/%b want 1/0", r0_gnt, r1_gnt); end
        checks++; if (ram_rden !== 1'b1 || ram_address !== 14'h0040) begin errors++;
            $display("FAIL lk_c_rd: got rden=%b addr=%h want 1 0040", ram_rden, ram_address); end
        next_cycle();
        r0_req = 1'b0;
        next_cycle();
        // E: r1's read (B+3) returns the merged word
        @(negedge clk);
        checks++; if (r1_rvalid !== 1'b1 || r0_rvalid !== 1'b0) begin errors++;
            $display("FAIL lk_e_rv: got %b/%b want 0/1", r0_rvalid, r1_rvalid); end
        checks++; if (r1_rdata !== exp_rd) begin errors++;
            $display("FAIL lk_e_rdata: got %h want %h", r1_rdata, exp_rd); end
        next_cycle();
        @(negedge clk);
        checks++; if (r0_rvalid !== 1'b1 || r1_rvalid !== 1'b0) begin errors++;
            $display("FAIL lk_f_rv: got %b/%b want 1/0", r0_rvalid, r1_rvalid); end
        checks++; if (r0_rdata !== dflt(14'h0020)) begin errors++;
            $display("FAIL lk_f_rdata: got %h want %h", r0_rdata, dflt(14'h0020)); end
        next_cycle();
        clear_inputs();
        next_cycle();
    endtask

    task automatic test_lock_release();
        r0_req = 1'b1; r0_lock = 1'b1; r0_addr = 14'h0050;
        @(negedge clk);
        checks++; if (r0_gnt !== 1'b1) begin errors++;
            $display("FAIL lr_a_gnt: got %b want 1", r0_gnt); end
        next_cycle();
        // owner drops its request: nobody is granted this cycle
        r0_req = 1'b0; r0_lock = 1'b0;
        r1_req = 1'b1; r1_addr = 14'h0060;
        @(negedge clk);
        checks++; if (r0_gnt !== 1'b0 || r1_gnt !== 1'b0) begin errors++;
            $display("FAIL lr_b_gnt: got %b/%b want 0/0", r0_gnt, r1_gnt); end
        next_cycle();
        @(negedge clk);
        checks++; if (r1_gnt !== 1'b1) begin errors++;
            $display("FAIL lr_c_gnt: got %b want 1", r1_gnt); end
        next_cycle();
        r1_req = 1'b0;
        @(negedge clk);
        checks++; if (r0_rvalid !== 1'b1 || r0_rdata !== dflt(14'h0050)) begin errors++;
            $display("FAIL lr_d_rv0: got v=%b %h want 1 %h", r0_rvalid, r0_rdata,
                     dflt(14'h0050)); end
        next_cycle();
        next_cycle();
        @(negedge clk);
        checks++; if (r1_rvalid !== 1'b1 || r1_rdata !== dflt(14'h0060)) begin errors++;
            $display("FAIL lr_f_rv1: got v=%b %h want 1 %h", r1_rvalid, r1_rdata,
                     dflt(14'h0060)); end
        next_cycle();
        next_cycle();
    endtask

    task automatic test_write_read();
        logic [DATA_W-1:0] wd;
        wd = {32{8'hA5}};
        r0_req = 1'b1; r0_we = 1'b1; r0_addr = 14'h3FFF; r0_be = 32'hFFFF_FFFF; r0_wdata = wd;
        @(negedge clk);
        checks++; if (r0_gnt !== 1'b1) begin errors++;
            $display("FAIL wr_gnt: got %b want 1", r0_gnt); end
        next_cycle();
        r0_we = 1'b0;
        @(negedge clk);
        checks++; if (r0_gnt !== 1'b1) begin errors++;
            $display("FAIL wr_rd_gnt: got %b want 1", r0_gnt); end
        checks++; if (ram_wren !== 1'b1 || ram_address !== 14'h3FFF || ram_wdata !== wd) begin
            errors++;
            $display("FAIL wr_ram: got wren=%b addr=%h want 1 3fff", ram_wren, ram_address); end
        next_cycle();
        r0_req = 1'b0;
        @(negedge clk);
        checks++; if (ram_rden !== 1'b1 || ram_wren !== 1'b0) begin errors++;
            $display("FAIL wr_rden: got rden=%b wren=%b want 1/0", ram_rden, ram_wren); end
        next_cycle();
        next_cycle();
        @(negedge clk);
        checks++; if (r0_rvalid !== 1'b1 || r0_rdata !== wd) begin errors++;
            $display("FAIL wr_readback: got v=%b %h want 1 %h", r0_rvalid, r0_rdata, wd); end
        next_cycle();
        clear_inputs();
        next_cycle();
    endtask

    task automatic test_back_to_back();
        bit                exp_rv;
        bit                exp_busy;
        logic [ADDR_W-1:0] exp_a;
        for (int k = 0; k < 8; k++) begin
            r0_req  = (k < 4);
            r0_addr = 14'h0300 + 14'(k);
            exp_rv   = (k >= 3) && (k <= 6);
            exp_busy = (k >= 1) && (k <= 6);
            exp_a    = 14'h0300 + 14'(k - 3);
            @(negedge clk);
            checks++; if (r0_gnt !== (k < 4)) begin errors++;
                $display("FAIL b2b_gnt[%0d]: got %b want %b", k, r0_gnt, (k < 4)); end
            checks++; if (r0_rvalid !== exp_rv) begin errors++;
                $display("FAIL b2b_rv[%0d]: got %b want %b", k, r0_rvalid, exp_rv); end
            if (exp_rv) begin
                checks++; if (r0_rdata !== dflt(exp_a)) begin errors++;
                    $display("FAIL b2b_rdata[%0d]: got %h want %h", k, r0_rdata, dflt(exp_a)); end
            end
            checks++; if (busy !== exp_busy) begin errors++;
                $display("FAIL b2b_busy[%0d]: got %b want %b", k, busy, exp_busy); end
            next_cycle();
        end
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_reset_mid_read();
        test_contention();
        test_lock();
        test_lock_release();
        test_write_read();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single 256-bit data-memory port between two requesters.
  - r0: SIMD processor load/store port.
  - r1: DMA/debug scanner.
- Sits between simd_processor / auxiliary master and dmem; drives dmem address, byteena, writeData, rden and wren.
- Round-robin arbitration with an optional lock, so either requester can run back-to-back transactions (read-modify-write).
- Tracks in-flight reads so returned data is steered to the requester that issued the read.

Parameters:
- ADDR_W, 14, dmem word address width.
- DATA_W, 256, data width.
- BE_W, 32, byte-enable width (DATA_W/8).
- READ_LATENCY, 2, cycles from ram_rden registered to ram_rdata valid (range 1..4).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- r0_req  in  1  requester 0 transaction request.
- r0_we  in  1  1 = write, 0 = read.
- r0_lock  in  1  keep ownership after this transaction.
- r0_addr  in  ADDR_W  word address.
- r0_be  in  BE_W  byte enables (writes only).
- r0_wdata  in  DATA_W  write data.
- r0_gnt  out  1  transaction accepted this cycle.
- r0_rvalid  out  1  read data valid pulse.
- r0_rdata  out  DATA_W  read data.
- r1_req, r1_we, r1_lock, r1_addr, r1_be, r1_wdata, r1_gnt, r1_rvalid, r1_rdata: same as r0 for requester 1.
- ram_address  out  ADDR_W  to dmem.
- ram_byteena  out  BE_W  to dmem.
- ram_wdata  out  DATA_W  to dmem.
- ram_rden  out  1  to dmem.
- ram_wren  out  1  to dmem.
- ram_rdata  in  DATA_W  from dmem.
- busy  out  1  any read in flight, or state not IDLE.

Behaviour:
- Reset (reset=0, async):
  - state=IDLE; rr pointer favours r0.
  - Read tracking pipeline cleared.
  - All outputs 0.
  - Reset mid-read discards the in-flight read; no rvalid is produced for it.
- FSM states: IDLE, OWN0, OWN1.
  - IDLE:
    - Only one requesting: grant it.
    - Both requesting: grant the one not granted last (rr pointer), then flip the pointer.
  - OWN0: only r0 can be granted; r1_gnt=0 even if r1_req.
  - OWN1: mirror of OWN0.
  - Transitions, evaluated on each granted transaction:
    - If granted requester's lock=1: next state OWNx.
    - If lock=0: next state IDLE.
  - OWNx with rx_req=0 for a cycle: return to IDLE, clear lock, resume arbitration next cycle.
- Grant is combinational in cycle T: rx_gnt = rx_req & eligible. At most one gnt per cycle.
- RAM side registered:
  - At T+1, ram_address/ram_byteena/ram_wdata/ram_rden/ram_wren carry the granted transaction.
  - Reads drive ram_byteena all-ones; writes pass rx_be.
  - Idle cycles: rden=wren=0; address/data hold last value.
- Read return:
  - A READ_LATENCY-deep shift register carries {valid, id} per issued read.
  - rx_rvalid pulses one cycle at T+1+READ_LATENCY with rx_rdata=ram_rdata.
  - rdata is registered with rvalid and holds until the next rvalid for that requester.
- Throughput:
  - One transaction per cycle, fully pipelined.
  - Up to READ_LATENCY+1 reads in flight.
- Writes complete on gnt; no response.
- Ordering: per requester, reads return in issue order. Read-after-write to the same address issued on consecutive cycles sees the new data.
- Simultaneous req with either requester locked: lock wins over round-robin.
- busy = (state!=IDLE) | any tracked read valid.

Optional Feature:
- Macro DMEM_ARB_FIXED_PRIO_EN.
- Defined:
  - IDLE arbitration is fixed priority: r0 always wins on contention.
  - rr pointer not implemented.
  - r1 may starve.
- Undefined: round-robin as above.
- Lock behaviour identical in both builds.

Test Plan:
- Reset mid-read:
  - Reset low 3 cycles, release; r0 read addr 0x0010.
  - Expect: r0_gnt same cycle; ram_rden=1 and ram_address=0x0010 next cycle; r0_rvalid 3 cycles after gnt with model data.
  - Assert reset one cycle after gnt: no rvalid, busy=0.
- Contention, round-robin:
  - r0 and r1 read continuously from 0x0100 / 0x0200.
  - Expect: gnt alternates r0, r1, r0, r1, starting with r0; each rvalid goes only to the issuer, data matching its address.
  - With DMEM_ARB_FIXED_PRIO_EN defined: r0 granted every cycle, r1_gnt stays 0.
- Lock:
  - r1 issues write 0x0040, lock=1, be=0x0000000F; then read 0x0040, lock=0.
  - r0_req held high throughout: r0_gnt=0 until r1 unlocks, then granted in the following cycle.
- Write then read:
  - r0 writes 0xA5.. with byteena 0xFFFFFFFF to 0x3FFF (max address), then reads 0x3FFF back-to-back.
  - Expect: read returns the written data.
- Pipelining:
  - r0 issues 4 back-to-back reads.
  - Expect: 4 consecutive rvalid pulses in order, starting cycle T+3; busy high until the last rvalid.
